// File: rtl/iot_event_arbiter.sv
// ---------------------------------------------------------------------------
// iot_event_arbiter
//
// Shares one active-device monitor counter between N_REQ IoT device ports.
// Each port raises a join (count up) or leave (count down) request. Requests
// are served round-robin, one event every two cycles. Illegal events (double
// join, leave while inactive, join when the count is saturated) are
// acknowledged with nack and never reach the monitor. A mirror of the monitor
// count and a per-port active map are kept alongside.
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   req_valid   in   N_REQ  per-port request, held high until ack
//   req_join    in   N_REQ  per-port direction: 1 = join, 0 = leave
//   clear_req   in   1      synchronous pulse: reset monitor and device states
//   ack         out  N_REQ  one-hot, one cycle: request consumed
//   nack        out  1      valid with ack: request rejected
//   mon_on_off  out  1      monitor on_off strobe, one cycle per counted event
//   mon_change  out  1      monitor direction, 1 = up, 0 = down (held when idle)
//   mon_rst     out  1      monitor synchronous reset, active high
//   active_map  out  N_REQ  bit i set while port i is counted as active
//   active_cnt  out  CNT_W  mirror of the monitor count
// ---------------------------------------------------------------------------
module iot_event_arbiter #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_valid,
   input  logic [N_REQ-1:0] req_join,
   input  logic             clear_req,
   output logic [N_REQ-1:0] ack,
   output logic             nack,
   output logic             mon_on_off,
   output logic             mon_change,
   output logic             mon_rst,
   output logic [N_REQ-1:0] active_map,
   output logic [CNT_W-1:0] active_cnt
);

   localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PTR_W1 = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic [PTR_W-1:0]   rrPtr_q,     rrPtr_d;
   logic [N_REQ-1:0]   ack_q,       ack_d;
   logic               nack_q,      nack_d;
   logic               monOnOff_q,  monOnOff_d;
   logic               monChange_q, monChange_d;
   logic               monRst_q,    monRst_d;
   logic [N_REQ-1:0]   activeMap_q, activeMap_d;
   logic [CNT_W-1:0]   activeCnt_q, activeCnt_d;

   logic               grantFound;
   logic [PTR_W-1:0]   grantIdx;
   logic [PTR_W1-1:0]  cand;
   logic               grantDir;
   logic               grantActive;
   logic               cntFull;
   logic               eventLegal;

   // Round-robin search: walk the ports starting at rrPtr_q, wrapping at
   // N_REQ, and take the first one with a pending request. The candidate is
   // wrapped by a single subtraction because rrPtr_q + offset < 2*N_REQ.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = {1'b0, rrPtr_q} + PTR_W1'(off);
         if (cand >= PTR_W1'(N_REQ)) begin
            cand = cand - PTR_W1'(N_REQ);
         end
         if (!grantFound && req_valid[cand[PTR_W-1:0]]) begin
            grantFound = 1'b1;
            grantIdx   = cand[PTR_W-1:0];
         end
      end
   end

   // Legality of the event for the winning port. A join needs the port to be
   // inactive and room left in the counter; a leave needs the port active.
   always_comb begin
      grantDir    = req_join[grantIdx];
      grantActive = activeMap_q[grantIdx];
      cntFull     = (activeCnt_q == {CNT_W{1'b1}});
      eventLegal  = (grantDir & ~grantActive & ~cntFull) |
                    (~grantDir & grantActive);
   end

   // Next-state and registered-output logic. Every output is computed here
   // and captured on the same edge as the state, so the ack/strobe pattern
   // seen during ISSUE and CLEAR is produced on the transition into them.
   // Clear is checked before arbitration so a simultaneous request waits.
   always_comb begin
      state_d     = state_q;
      rrPtr_d     = rrPtr_q;
      ack_d       = '0;
      nack_d      = 1'b0;
      monOnOff_d  = 1'b0;
      monChange_d = monChange_q;
      monRst_d    = 1'b0;
      activeMap_d = activeMap_q;
      activeCnt_d = activeCnt_q;

      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d     = CLEAR;
               monRst_d    = 1'b1;
               activeMap_d = '0;
               activeCnt_d = '0;
            end else if (grantFound) begin
               state_d         = ISSUE;
               ack_d[grantIdx] = 1'b1;
               if (grantIdx == PTR_W'(N_REQ - 1)) begin
                  rrPtr_d = '0;
               end else begin
                  rrPtr_d = grantIdx + PTR_W'(1);
               end
               if (eventLegal) begin
                  monOnOff_d            = 1'b1;
                  monChange_d           = grantDir;
                  activeMap_d[grantIdx] = ~grantActive;
                  if (grantDir) begin
                     activeCnt_d = activeCnt_q + CNT_W'(1);
                  end else begin
                     activeCnt_d = activeCnt_q - CNT_W'(1);
                  end
               end else begin
                  nack_d = 1'b1;
               end
            end
         end

         ISSUE: begin
            if (clear_req) begin
               state_d     = CLEAR;
               monRst_d    = 1'b1;
               activeMap_d = '0;
               activeCnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end

         CLEAR: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. mon_rst resets high so the monitor sees a
   // reset edge on the first clock after rst_n is released; mon_change
   // resets to "up".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rrPtr_q     <= '0;
         ack_q       <= '0;
         nack_q      <= 1'b0;
         monOnOff_q  <= 1'b0;
         monChange_q <= 1'b1;
         monRst_q    <= 1'b1;
         activeMap_q <= '0;
         activeCnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rrPtr_q     <= rrPtr_d;
         ack_q       <= ack_d;
         nack_q      <= nack_d;
         monOnOff_q  <= monOnOff_d;
         monChange_q <= monChange_d;
         monRst_q    <= monRst_d;
         activeMap_q <= activeMap_d;
         activeCnt_q <= activeCnt_d;
      end
   end

   assign ack        = ack_q;
   assign nack       = nack_q;
   assign mon_on_off = monOnOff_q;
   assign mon_change = monChange_q;
   assign mon_rst    = monRst_q;
   assign active_map = activeMap_q;
   assign active_cnt = activeCnt_q;

endmodule
